// File: rtl/seven_segment_pkg.sv
// -----------------------------------------------------------------------------
// seven_segment_pkg
// Shared definitions for the six-digit decimal display path. The display
// parser and the digit decoder both take BLANK_CODE from here so the two
// directions agree on what "blank" means.
// Contents:
//   DIGIT_COUNT, VALUE_WIDTH, ACC_WIDTH, BLANK_CODE  - sizing and code points
//   digit_code_t, digit_array_t                      - digit code containers
//   decoder_state_t                                  - decoder FSM states
//   code_to_digit()                                  - code -> decimal weight
//   digit_set_error()                                - malformed-set detector
// -----------------------------------------------------------------------------
package seven_segment_pkg;

    localparam int DIGIT_COUNT = 6;
    localparam int VALUE_WIDTH = 20;
    // Six decimal digits need 20 bits; 24 leaves headroom for the x10 step.
    localparam int ACC_WIDTH   = 24;
    localparam logic [3:0] BLANK_CODE = 4'd10;

    typedef logic [3:0] digit_code_t;
    typedef digit_code_t [DIGIT_COUNT-1:0] digit_array_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } decoder_state_t;

    // Blank and invalid codes carry no weight; only 0-9 pass through.
    function automatic logic [3:0] code_to_digit(input digit_code_t code);
        logic [3:0] digit;
        if (code <= 4'd9) begin
            digit = code;
        end else begin
            digit = 4'd0;
        end
        return digit;
    endfunction

    // A set is malformed if it holds an invalid code, a blank below a
    // non-blank digit, or a blank in the units position. Scanning from the
    // top, "seen" marks that a real digit has already appeared.
    function automatic logic digit_set_error(input digit_array_t digits);
        logic err;
        logic seen;
        err  = 1'b0;
        seen = 1'b0;
        for (int i = DIGIT_COUNT - 1; i >= 0; i--) begin
            if (digits[i] > BLANK_CODE) begin
                err  = 1'b1;
                seen = 1'b1;
            end else if (digits[i] == BLANK_CODE) begin
                if (seen) begin
                    err = 1'b1;
                end else begin
                    err = err;
                end
            end else begin
                seen = 1'b1;
            end
        end
        if (digits[0] == BLANK_CODE) begin
            err = 1'b1;
        end else begin
            err = err;
        end
        return err;
    endfunction

endpackage

// File: rtl/seven_segment_digit_decoder_mac.sv
// -----------------------------------------------------------------------------
// decimal_mac_step
// One Horner step of the decimal-to-binary conversion: next = acc*10 + digit.
// The multiply is built from two shifts and an add, and the incoming code is
// sanitized so blank/invalid codes add nothing.
// Ports:
//   acc      in   current accumulator
//   code     in   digit code for the position being folded in
//   next_acc out  acc*10 + code_to_digit(code)
// -----------------------------------------------------------------------------
module decimal_mac_step
    import seven_segment_pkg::*;
(
    input  logic [ACC_WIDTH-1:0] acc,
    input  digit_code_t          code,
    output logic [ACC_WIDTH-1:0] next_acc
);

    logic [3:0] digit_s;

    // Multiply by ten as (acc<<3)+(acc<<1) and add the sanitized digit.
    always_comb begin
        digit_s  = code_to_digit(code);
        next_acc = (acc << 3) + (acc << 1) + {{(ACC_WIDTH-4){1'b0}}, digit_s};
    end

endmodule

// File: rtl/seven_segment_digit_decoder.sv
// -----------------------------------------------------------------------------
// seven_segment_digit_decoder
// Turns a six-digit decimal display code set (leading blanks allowed) back
// into a binary value, one digit per clock, most significant digit first.
// Optional build macro: SEVEN_SEGMENT_DIGIT_CHECK_EN - when defined, out_error
// flags malformed sets; when undefined, out_error is tied low.
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous active-high reset; aborts any conversion
//   in_digits  in   digit codes, index 0 = units
//   in_valid   in   in_digits presented
//   in_ready   out  high only in IDLE and never while reset is high
//   out_value  out  converted value, held through the DONE stall
//   out_error  out  malformed-set flag, qualified by out_valid
//   out_valid  out  result available
//   out_ready  in   consumer takes the result
// -----------------------------------------------------------------------------
module seven_segment_digit_decoder
    import seven_segment_pkg::*;
#(
    parameter int DIGIT_COUNT = 6,
    parameter int VALUE_WIDTH = 20
) (
    input  logic                   clock,
    input  logic                   reset,
    input  digit_array_t           in_digits,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [VALUE_WIDTH-1:0] out_value,
    output logic                   out_error,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam logic [2:0] LAST_INDEX = 3'(DIGIT_COUNT - 1);

    decoder_state_t         state_r;
    decoder_state_t         next_state_s;
    digit_array_t           digits_r;
    logic [ACC_WIDTH-1:0]   acc_r;
    logic [ACC_WIDTH-1:0]   next_acc_s;
    logic [2:0]             index_r;
    logic [VALUE_WIDTH-1:0] out_value_r;
    logic                   out_error_r;
    logic                   err_s;
    logic                   in_ready_s;
    logic                   out_valid_s;

    decimal_mac_step u_mac (
        .acc      (acc_r),
        .code     (digits_r[index_r]),
        .next_acc (next_acc_s)
    );

`ifdef SEVEN_SEGMENT_DIGIT_CHECK_EN
    // The whole latched set is judged at once when the result is transferred.
    always_comb begin
        err_s = digit_set_error(digits_r);
    end
`else
    // Without the check build, out_error never asserts.
    always_comb begin
        err_s = 1'b0;
    end
`endif

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    next_state_s = CONVERT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            CONVERT: begin
                if (index_r == 3'd0) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = CONVERT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // FSM outputs; in_ready is masked by reset so nothing is accepted then.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready_s  = !reset;
                out_valid_s = 1'b0;
            end
            CONVERT: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
            DONE: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b1;
            end
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Datapath: latch digits on accept, fold one digit per CONVERT cycle,
    // transfer the truncated accumulator after the units digit.
    always_ff @(posedge clock) begin
        if (reset) begin
            digits_r    <= '0;
            acc_r       <= '0;
            index_r     <= 3'd0;
            out_value_r <= '0;
            out_error_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        digits_r <= in_digits;
                        acc_r    <= '0;
                        index_r  <= LAST_INDEX;
                    end
                end
                CONVERT: begin
                    acc_r <= next_acc_s;
                    if (index_r == 3'd0) begin
                        out_value_r <= VALUE_WIDTH'(next_acc_s);
                        out_error_r <= err_s;
                    end else begin
                        index_r <= index_r - 3'd1;
                    end
                end
                DONE: begin
                    acc_r <= acc_r;
                end
                default: begin
                    acc_r <= '0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_value = out_value_r;
    assign out_error = out_error_r;

endmodule

// File: tb/tb_seven_segment_digit_decoder.sv
module tb_seven_segment_digit_decoder;
    import seven_segment_pkg::*;

`ifdef SEVEN_SEGMENT_DIGIT_CHECK_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset;
    digit_array_t in_digits;
    logic         in_valid;
    logic         in_ready;
    logic [19:0]  out_value;
    logic         out_error;
    logic         out_valid;
    logic         out_ready;

    seven_segment_digit_decoder #(.DIGIT_COUNT(6), .VALUE_WIDTH(20)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_digits (in_digits),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_value (out_value),
        .out_error (out_error),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal value as a sum of digit * 10^position; non-decimal codes weigh 0.
    function automatic int model_value(input digit_array_t d);
        int v = 0;
        int p = 1;
        for (int i = 0; i < 6; i++) begin
            if (d[i] <= 4'd9) v += int'(d[i]) * p;
            p *= 10;
        end
        return v;
    endfunction

    // Malformed: invalid code, blank below the highest non-blank, or blank units.
    function automatic bit model_err(input digit_array_t d);
        int h = -1;
        bit e = 1'b0;
        if (!CK) return 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (d[i] > 4'd10) e = 1'b1;
            if (d[i] != 4'd10) h = i;
        end
        for (int i = 0; i < h; i++) begin
            if (d[i] == 4'd10) e = 1'b1;
        end
        if (d[0] == 4'd10) e = 1'b1;
        return e;
    endfunction

    // Behavioural timing model: 0 idle, 1 converting (6 cycles), 2 result held.
    int m_phase = 0, m_cnt = 0, m_val = 0, m_cap_val = 0, m_accepts = 0, m_completes = 0;
    bit m_err = 1'b0, m_cap_err = 1'b0, started = 1'b0;
    int dut_completes = 0;

    always @(posedge clock) begin
        started = 1'b1;
        if (out_valid === 1'b1 && out_ready === 1'b1 && reset === 1'b0) dut_completes++;
        if (reset) begin
            m_phase = 0;
            m_val   = 0;
            m_err   = 1'b0;
        end else if (m_phase == 0) begin
            if (in_valid) begin
                m_cap_val = model_value(in_digits);
                m_cap_err = model_err(in_digits);
                m_cnt     = 6;
                m_phase   = 1;
                m_accepts++;
            end
        end else if (m_phase == 1) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_val   = m_cap_val;
                m_err   = m_cap_err;
                m_phase = 2;
            end
        end else begin
            if (out_ready) begin
                m_phase = 0;
                m_completes++;
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clock) begin
        if (started) begin
            check("in_ready", in_ready, (m_phase == 0 && !reset) ? 1 : 0);
            check("out_valid", out_valid, (m_phase == 2) ? 1 : 0);
            check("out_value", out_value, m_val);
            if (m_phase == 2) check("out_error", out_error, m_err);
        end
    end

    task automatic wait_accept(input int target);
        int g = 0;
        while (m_accepts < target && g < 100) begin
            @(negedge clock);
            g++;
        end
        if (m_accepts < target) check("accept_timeout", m_accepts, target);
    endtask

    task automatic convert_directed(input digit_array_t d, input int exp_val, input bit exp_err);
        int cnt;
        check("model_pin_val", model_value(d), exp_val);
        check("model_pin_err", model_err(d), exp_err);
        @(negedge clock);
        #1;
        in_valid  = 1'b1;
        in_digits = d;
        out_ready = 1'b1;
        wait_accept(m_accepts + 1);
        #1;
        in_valid = 1'b0;
        cnt = 1;
        while (out_valid !== 1'b1 && cnt < 20) begin
            @(negedge clock);
            cnt++;
        end
        check("latency_cycle", cnt, 7);
        check("dir_value", out_value, exp_val);
        check("dir_error", out_error, exp_err);
        @(negedge clock);
        check("in_ready_back", in_ready, 1);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        digit_array_t d;
        int base_acc, base_cmp, g, acc0;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_digits = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_value", out_value, 0);
        check("rst_out_error", out_error, 0);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_in_ready", in_ready, 1);

        convert_directed({4'd10, 4'd10, 4'd10, 4'd10, 4'd1, 4'd6}, 16, 1'b0);
        convert_directed({4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9}, 999999, 1'b0);
        convert_directed({4'd10, 4'd10, 4'd10, 4'd10, 4'd10, 4'd0}, 0, 1'b0);
        convert_directed({4'd10, 4'd1, 4'd10, 4'd3, 4'd0, 4'd0}, 10300, CK);
        convert_directed({4'd10, 4'd10, 4'd10, 4'd10, 4'd10, 4'd12}, 0, CK);

        // Stall in DONE for 20 cycles while junk is offered on the input side.
        @(negedge clock);
        #1;
        in_valid  = 1'b1;
        in_digits = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        out_ready = 1'b0;
        wait_accept(m_accepts + 1);
        #1;
        in_valid = 1'b0;
        acc0 = m_accepts;
        g = 0;
        while (out_valid !== 1'b1 && g < 20) begin
            @(negedge clock);
            g++;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("stall_value", out_value, 123456);
            check("stall_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            #1;
            in_valid  = 1'($urandom_range(0, 1));
            in_digits = digit_array_t'($urandom);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        check("release_idle", in_ready, 1);
        check("release_valid", out_valid, 0);
        check("stall_no_accept", m_accepts, acc0);
        #1;
        out_ready = 1'b0;

        // Reset in the third CONVERT cycle aborts without a result.
        in_valid  = 1'b1;
        in_digits = {4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3};
        wait_accept(m_accepts + 1);
        #1;
        in_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        check("abort_valid", out_valid, 0);
        check("abort_value", out_value, 0);
        check("abort_in_ready", in_ready, 0);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("abort_ready_back", in_ready, 1);
        convert_directed({4'd10, 4'd10, 4'd10, 4'd4, 4'd2, 4'd0}, 420, 1'b0);

        // Back-to-back random sets with random backpressure; the last ten
        // may contain any code.
        base_acc = m_accepts;
        base_cmp = m_completes;
        @(negedge clock);
        for (int k = 0; k < 60; k++) begin
            if (k < 50) begin
                int sig = $urandom_range(1, 6);
                for (int i = 0; i < 6; i++) begin
                    d[i] = (i < sig) ? 4'($urandom_range(0, 9)) : 4'd10;
                end
            end else begin
                d = digit_array_t'($urandom);
            end
            #1;
            in_valid  = 1'b1;
            in_digits = d;
            g = 0;
            while (m_accepts < base_acc + k + 1 && g < 200) begin
                @(negedge clock);
                #1;
                out_ready = 1'($urandom_range(0, 1));
                g++;
            end
            if (m_accepts < base_acc + k + 1) check("rand_accept_timeout", m_accepts, base_acc + k + 1);
        end
        in_valid = 1'b0;
        g = 0;
        while (m_completes < base_cmp + 60 && g < 500) begin
            @(negedge clock);
            #1;
            out_ready = 1'($urandom_range(0, 1));
            g++;
        end
        out_ready = 1'b0;
        check("rand_completions", m_completes - base_cmp, 60);
        check("dut_completions", dut_completes, m_completes);
        repeat (2) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
